// File: rtl/m68k_wb_bridge.sv
// Bridges the asynchronous 68000 bus-slave handshake onto a 32-bit big-endian
// Wishbone master. Each 68000 strobe cycle becomes exactly one Wishbone cycle.
module m68k_wb_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        AS_N,
    input  logic        UDS_N,
    input  logic        LDS_N,
    input  logic        RW,
    input  logic [23:1] A,
    input  logic [15:0] D_I,
    output logic [15:0] D_O,
    output logic        D_OE,
    output logic        DTACK_N,
    output logic        BERR_N,
    output logic [23:0] ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        CYC_O,
    output logic        STB_O,
    input  logic        ACK_I,
    input  logic        ERR_I
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, ACKED, FAULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    strb_s1_q, strb_s1_d;   // {AS, UDS, LDS}, active low
    logic [2:0]    strb_s2_q, strb_s2_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic          a1_q, a1_d;
    logic [3:0]    sel_q, sel_d;
    logic [23:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [15:0]   d_o_q, d_o_d;
    logic          d_oe_q, d_oe_d;
    logic          dtack_n_q, dtack_n_d;
    logic          berr_n_q, berr_n_d;

    logic as_s, uds_s, lds_s;
    assign {as_s, uds_s, lds_s} = strb_s2_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        strb_s1_d = {AS_N, UDS_N, LDS_N};
        strb_s2_d = strb_s1_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        a1_d      = a1_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        d_o_d     = d_o_q;
        d_oe_d    = d_oe_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;

        case (state_q)
            IDLE: begin
                if (!as_s && (!uds_s || !lds_s)) begin
                    state_d = BUS;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    we_d    = ~RW;
                    a1_d    = A[1];
                    adr_d   = {A[23:2], 2'b00};
                    dat_d   = {D_I, D_I};
                    // Even halfword sits in the upper lanes of a big-endian word.
                    sel_d   = A[1] ? {2'b00, ~uds_s, ~lds_s} : {~uds_s, ~lds_s, 2'b00};
                end
            end
            BUS: begin
                if (ERR_I || (!ACK_I && cnt_q == CNT_LAST)) begin
                    state_d  = FAULT;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    berr_n_d = 1'b0;
                end else if (ACK_I) begin
                    state_d   = ACKED;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    dtack_n_d = 1'b0;
                    if (!we_q) begin
                        d_o_d  = a1_q ? DAT_I[15:0] : DAT_I[31:16];
                        d_oe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACKED, FAULT: begin
                if (as_s) begin
                    state_d   = IDLE;
                    dtack_n_d = 1'b1;
                    berr_n_d  = 1'b1;
                    d_oe_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            strb_s1_q <= 3'b111;
            strb_s2_q <= 3'b111;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            a1_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            d_o_q     <= '0;
            d_oe_q    <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            strb_s1_q <= strb_s1_d;
            strb_s2_q <= strb_s2_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            a1_q      <= a1_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            d_o_q     <= d_o_d;
            d_oe_q    <= d_oe_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    assign CYC_O   = cyc_q;
    assign STB_O   = cyc_q;
    assign WE_O    = we_q;
    assign SEL_O   = sel_q;
    assign ADR_O   = adr_q;
    assign DAT_O   = dat_q;
    assign D_O     = d_o_q;
    assign D_OE    = d_oe_q;
    assign DTACK_N = dtack_n_q;
    assign BERR_N  = berr_n_q;

endmodule

// File: doc/m68k_wb_bridge.md
M68K_WB_BRIDGE -- requirements
Module: m68k_wb_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 15, number of cycles STB_O may stay high without ACK_I/ERR_I before the bridge signals a bus error.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port CLK_I  in  1  system clock; all state changes on its rising edge.
REQ-004 Port RST_I  in  1  synchronous active-high reset.
REQ-005 Port AS_N  in  1  68000 address strobe, active low.
REQ-006 Port UDS_N  in  1  68000 upper data strobe (D[15:8]), active low.
REQ-007 Port LDS_N  in  1  68000 lower data strobe (D[7:0]), active low.
REQ-008 Port RW  in  1  68000 direction; 1 = read, 0 = write.
REQ-009 Port A  in  23  68000 address A[23:1].
REQ-010 Port D_I  in  16  68000 write data.
REQ-011 Port D_O  out  16  read data to the 68000.
REQ-012 Port D_OE  out  1  drive enable for D_O.
REQ-013 Port DTACK_N  out  1  data transfer acknowledge, active low.
REQ-014 Port BERR_N  out  1  bus error, active low.
REQ-015 Ports ADR_O out 24, DAT_O out 32, DAT_I in 32, SEL_O out 4, WE_O out 1, CYC_O out 1, STB_O out 1, ACK_I in 1, ERR_I in 1: Wishbone master, 32-bit big-endian.

Function
REQ-016 AS_N, UDS_N and LDS_N each pass through a 2-flop synchronizer; the FSM uses only the synchronized copies.
REQ-017 States: IDLE, BUS, ACKED, FAULT.
REQ-018 IDLE -> BUS when sync AS low and at least one sync DS low; CYC_O/STB_O go high on that edge, 2 edges after the first edge sampling both strobes low.
REQ-019 On the IDLE->BUS edge, latch ADR_O = {A[23:2],2'b00}, WE_O = ~RW, DAT_O = {D_I,D_I}.
REQ-020 On the same edge, latch SEL_O: A[1]=0 -> {~UDS,~LDS,0,0}; A[1]=1 -> {0,0,~UDS,~LDS} (sync strobes).
REQ-021 BUS, ERR_I=1 -> FAULT: CYC_O/STB_O/WE_O low, BERR_N low on the next edge; ERR_I wins over simultaneous ACK_I.
REQ-022 BUS, ACK_I=1, ERR_I=0 -> ACKED: CYC_O/STB_O/WE_O low, DTACK_N low on the next edge.
REQ-023 On the BUS->ACKED edge of a read, latch D_O = A[1] ? DAT_I[15:0] : DAT_I[31:16], and set D_OE=1.
REQ-024 Timeout counter: cleared entering BUS, +1 per BUS cycle without ACK_I/ERR_I.
REQ-025 Timeout: counter==TIMEOUT-1 with no ACK_I/ERR_I -> FAULT; STB_O is high exactly TIMEOUT cycles.
REQ-026 ACKED/FAULT hold DTACK_N/BERR_N (and D_OE/D_O for reads) until sync AS is high; then -> IDLE, DTACK_N=1, BERR_N=1, D_OE=0 on that edge.
REQ-027 A new cycle is never started from ACKED/FAULT; at least one IDLE cycle with sync AS high precedes the next BUS.
REQ-028 AS_N rising while in BUS does not abort the Wishbone cycle; the bridge completes it, then returns to IDLE within one cycle.
REQ-029 SEL_O, ADR_O, DAT_O and WE_O are stable for the whole time CYC_O is high.
REQ-030 DTACK_N and BERR_N are never low simultaneously.

Reset
REQ-031 RST_I high at an edge -> state IDLE, counter 0, synchronizers 1, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, D_O=0, D_OE=0, DTACK_N=1, BERR_N=1, regardless of state (incl. mid-BUS).

Verification
REQ-032 Read, A=0x000100, UDS_N=LDS_N=0, slave ACK same cycle, DAT_I=0x11223344 -> ADR_O=0x000100, SEL_O=4'b1100, one STB cycle, D_O=0x1122, DTACK_N low until AS_N high.
REQ-033 Byte write, A=0x000102, LDS_N=0 only, D_I=0x00AB -> SEL_O=4'b0001, DAT_O=0x00AB00AB, WE_O=1, DTACK_N low, D_OE stays 0.
REQ-034 Slave never acks, TIMEOUT=15 -> STB_O high exactly 15 cycles, then BERR_N low, DTACK_N stays 1.
REQ-035 ACK_I and ERR_I high together -> FAULT: BERR_N low, DTACK_N stays 1, D_OE stays 0.
REQ-036 RST_I pulsed while STB_O high -> next edge: CYC_O=STB_O=0, DTACK_N=BERR_N=1, state IDLE.
REQ-037 Back-to-back reads, AS_N high 1 clock between -> two separate Wishbone cycles, DTACK_N released between them.
